// File: rtl/readout_frame_packer_if.sv
// readout_frame_packer_if: sample input, downstream FIFO write port and status bundle
interface readout_frame_packer_if #(
  parameter int DEPTH = 4
);
  logic                   en;
  logic                   done;
  logic [63:0]            data2pipe;
  logic                   fifo_full;
  logic                   wr_en;
  logic [31:0]            wr_data;
  logic [15:0]            drop_cnt;
  logic [$clog2(DEPTH):0] q_level;
  modport master (
    output en, done, data2pipe, fifo_full,
    input  wr_en, wr_data, drop_cnt, q_level
  );
  modport slave (
    input  en, done, data2pipe, fifo_full,
    output wr_en, wr_data, drop_cnt, q_level
  );
endinterface

// File: rtl/readout_frame_packer.sv
// readout_frame_packer: packs 40-bit conversion samples into tagged 32-bit word pairs for the host pipe FIFO
module readout_frame_packer #(
  parameter int DEPTH = 4
) (
  input logic                   SYS_CLK,
  input logic                   RST,
  readout_frame_packer_if.slave bus
);
  localparam int SEQ_W = 11;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = SEQ_W + 40;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT1 = 2'd1} state_t;
  state_t           r_state;
  logic [SEQ_W-1:0] r_seq;
  logic             r_in_vld;
  logic [SW-1:0]    r_in;
  logic [SW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_level;
  logic             r_ovf;
  logic [15:0]      r_drop;
  logic             r_wr_en;
  logic [31:0]      r_wr_data;
  logic [31:0]      r_word1;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic [SW-1:0]    w_head;
  logic [31:0]      w_word0;
  logic [7:0]       w_chk;
  logic             w_unused_hi;
  assign w_unused_hi = ^bus.data2pipe[63:40];
  assign w_push  = r_in_vld && (r_level < FULL);
  assign w_drop  = r_in_vld && !w_push;
  assign w_pop   = (r_state == IDLE) && (r_level != '0) && !bus.fifo_full;
  assign w_head  = r_mem[r_rp];
  assign w_word0 = {4'hA, r_ovf, w_head[SW-1:40], w_head[39:24]};
  assign w_chk   = w_word0[31:24] ^ w_word0[23:16] ^ w_word0[15:8] ^ w_word0[7:0]
                 ^ w_head[23:16] ^ w_head[15:8] ^ w_head[7:0];
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_data  = r_wr_data;
  assign bus.drop_cnt = r_drop;
  assign bus.q_level  = r_level;
  // Capture a strobed sample with its sequence tag; the tag advances even if the sample is later dropped
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_in_vld <= 1'b0;
      r_in     <= '0;
      r_seq    <= '0;
    end else begin
      r_in_vld <= bus.en & bus.done;
      r_in     <= {r_seq, bus.data2pipe[39:0]};
      r_seq    <= !bus.en ? '0 : bus.done ? r_seq + 1'b1 : r_seq;
    end
  end
  // Sample queue storage; slot contents need no reset since pointers define validity
  always_ff @(posedge SYS_CLK) begin
    if (w_push) r_mem[r_wp] <= r_in;
  end
  // Queue pointers and occupancy; a pop in the same cycle does not make room for a push
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      r_wp    <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
  // Saturating drop counter and overflow flag; a fresh drop outranks the clear on word0 emission
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_drop <= (w_drop && r_drop != 16'hFFFF) ? r_drop + 16'd1 : r_drop;
      r_ovf  <= w_drop ? 1'b1 : w_pop ? 1'b0 : r_ovf;
    end
  end
  // Emitter: word0 on pop, word1 of the same held sample next, each only while the FIFO has room
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_word1   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wr_en <= w_pop;
          if (w_pop) begin
            r_wr_data <= w_word0;
            r_word1   <= {w_head[23:0], w_chk};
            r_state   <= EMIT1;
          end
        end
        EMIT1: begin
          r_wr_en <= !bus.fifo_full;
          if (!bus.fifo_full) begin
            r_wr_data <= r_word1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_wr_en <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
